// File: rtl/calc_pkg.sv
// calc_pkg: shared opcode and command definitions for the button command encoder.
//   OP_*          : opcode values carried on cmd_op
//   BOUND_DEFAULT : default debounce stability window in clock cycles
//   cmd_t         : one queued command {opcode, operand}
//   pick_op       : turns simultaneous press events into the winning opcode
package calc_pkg;

    localparam int BOUND_DEFAULT = 1000000;

    typedef enum logic [1:0] {
        OP_LOAD = 2'd0,
        OP_SQRT = 2'd1,
        OP_MUL  = 2'd2,
        OP_ADD  = 2'd3
    } op_e;

    typedef struct packed {
        op_e        op;
        logic [3:0] operand;
    } cmd_t;

    // Event bits are {SOUTH,WEST,NORTH,EAST}; SOUTH has the highest priority.
    function automatic op_e pick_op(input logic [3:0] ev);
        return ev[3] ? OP_LOAD : ev[2] ? OP_SQRT : ev[1] ? OP_MUL : OP_ADD;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronizes and debounces one raw button, flags its presses.
//   clk, rst_n : clock, asynchronous active-low reset
//   din        : raw asynchronous button level
//   level      : debounced button state
//   rise       : high for the one cycle in which the debounced state goes 0->1
module btn_debounce #(
    parameter int BOUND = calc_pkg::BOUND_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise
);

    localparam int CW = (BOUND > 2) ? $clog2(BOUND) : 1;
    localparam logic [CW-1:0] LAST = CW'(BOUND - 1);

    logic          meta_q, meta_d;
    logic          sync_q, sync_d;
    logic          state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // The counter tracks consecutive synchronized samples that disagree with
    // the debounced state; the BOUND-th such sample commits the new state.
    always_comb begin
        meta_d  = din;
        sync_d  = meta_q;
        cnt_d   = '0;
        state_d = state_q;
        if (sync_q != state_q) begin
            if (cnt_q == LAST) state_d = sync_q;
            else cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            state_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            meta_q  <= meta_d;
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The press is flagged in the cycle whose edge commits the new state, so
    // the command can be queued on that same edge.
    assign level = state_q;
    assign rise  = state_d & ~state_q;

endmodule

// File: rtl/btn_cmd_encoder.sv
// btn_cmd_encoder: turns debounced button presses into queued calculator commands.
//   clk, rst_n  : clock, asynchronous active-low reset
//   btn[3:0]    : raw buttons {SOUTH,WEST,NORTH,EAST}
//   sw[3:0]     : raw operand switches
//   cmd_valid   : a command is at the head of the 2-entry queue
//   cmd_ready   : consumer accepts the head command this cycle
//   cmd_op      : head opcode (0 LOAD, 1 SQRT, 2 MUL, 3 ADD)
//   cmd_operand : switch value captured with the head command
//   overflow    : sticky, a press was lost to priority or a full queue
module btn_cmd_encoder
    import calc_pkg::*;
#(
    parameter int BOUND = BOUND_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] btn,
    input  logic [3:0] sw,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [1:0] cmd_op,
    output logic [3:0] cmd_operand,
    output logic       overflow
);

    logic [3:0] rise;
    logic [3:0] level;
    logic [3:0] sw_meta_q, sw_meta_d;
    logic [3:0] sw_sync_q, sw_sync_d;
    cmd_t [1:0] mem_q, mem_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       overflow_q, overflow_d;
    logic       push, pop, full, accept, multi;
    cmd_t       new_cmd;

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_btn
            btn_debounce #(.BOUND(BOUND)) u_deb (
                .clk   (clk),
                .rst_n (rst_n),
                .din   (btn[g]),
                .level (level[g]),
                .rise  (rise[g])
            );
        end
    endgenerate

    always_comb begin
        sw_meta_d = sw;
        sw_sync_d = sw_meta_q;
        // More than one press bit set means the lower-priority ones are lost.
        multi = |(rise & (rise - 4'd1));
        push = |rise;
        pop = (count_q != 2'd0) && cmd_ready;
        full = count_q == 2'd2;
        // A pop on the same edge frees the slot, so a full queue still takes the push.
        accept = push && (!full || pop);
        new_cmd.op = pick_op(rise);
        new_cmd.operand = sw_sync_q;
        mem_d = mem_q;
        if (accept) mem_d[wr_ptr_q] = new_cmd;
        wr_ptr_d = wr_ptr_q ^ accept;
        rd_ptr_d = rd_ptr_q ^ pop;
        count_d = count_q + {1'b0, accept} - {1'b0, pop};
        overflow_d = overflow_q | multi | (push && !accept);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            mem_q      <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            overflow_q <= 1'b0;
        end else begin
            sw_meta_q  <= sw_meta_d;
            sw_sync_q  <= sw_sync_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign cmd_valid   = count_q != 2'd0;
    assign cmd_op      = mem_q[rd_ptr_q].op;
    assign cmd_operand = mem_q[rd_ptr_q].operand;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_btn_cmd_encoder.sv
// tb_btn_cmd_encoder: directed and randomized checks of btn_cmd_encoder against a reference model.
module tb_btn_cmd_encoder;

    localparam int BOUND = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] btn = '0;
    logic [3:0] sw = '0;
    logic       cmd_ready = 1'b0;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic [3:0] cmd_operand;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    btn_cmd_encoder #(.BOUND(BOUND)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn         (btn),
        .sw          (sw),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_operand (cmd_operand),
        .overflow    (overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: two-sample delay for synchronization, a run length of
    // disagreeing samples per button, and a queue of {op, operand} commands.
    logic [3:0] m_p1, m_p2, m_sw1, m_sw2, m_st;
    int         m_run[4];
    logic       m_ovf;
    logic [5:0] q[$];

    task automatic model_clear();
        m_p1 = '0; m_p2 = '0; m_sw1 = '0; m_sw2 = '0; m_st = '0; m_ovf = 1'b0;
        for (int b = 0; b < 4; b++) m_run[b] = 0;
        q.delete();
    endtask

    task automatic model_step();
        int hi;
        int n;
        hi = -1;
        n = 0;
        for (int b = 0; b < 4; b++) begin
            if (m_p2[b] != m_st[b]) begin
                m_run[b]++;
                if (m_run[b] == BOUND) begin
                    m_st[b] = m_p2[b];
                    m_run[b] = 0;
                    if (m_st[b]) begin n++; hi = b; end
                end
            end else m_run[b] = 0;
        end
        if (n > 1) m_ovf = 1'b1;
        if (q.size() > 0 && cmd_ready) void'(q.pop_front());
        if (n > 0) begin
            if (q.size() < 2) q.push_back({2'(3 - hi), m_sw2});
            else m_ovf = 1'b1;
        end
        m_p2 = m_p1; m_p1 = btn; m_sw2 = m_sw1; m_sw1 = sw;
    endtask

    // One clock: advance the model on the edge, compare on the falling edge.
    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("valid", 32'(cmd_valid), 32'(q.size() > 0));
        if (q.size() > 0) check("head", 32'({cmd_op, cmd_operand}), 32'(q[0]));
        check("ovf", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(cmd_valid), 32'd0);
        check("rst_op", 32'(cmd_op), 32'd0);
        check("rst_operand", 32'(cmd_operand), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic press(input logic [3:0] b, input logic [3:0] s, input int hold);
        btn = b; sw = s;
        run(hold);
        btn = '0;
        run(8);
    endtask

    int         nv, nv2, lat;
    logic [5:0] got_cmd;

    initial begin
        model_clear();
        #2;
        do_reset();

        // Single WEST press, consumer always ready
        btn = 4'b0100; sw = 4'h9; cmd_ready = 1'b1; nv = 0; got_cmd = '0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (cmd_valid) begin nv++; got_cmd = {cmd_op, cmd_operand}; end
        end
        check("west_cycles", 32'(nv), 32'd1);
        check("west_cmd", 32'(got_cmd), 32'h19);
        btn = '0; run(10);

        // NORTH bouncing every 2 cycles, then held
        sw = 4'h5; nv = 0; nv2 = 0;
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) btn[1] = ~btn[1];
            step();
            if (cmd_valid) nv++;
        end
        btn[1] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (cmd_valid) begin nv2++; got_cmd = {cmd_op, cmd_operand}; end
        end
        check("bounce_none", 32'(nv), 32'd0);
        check("bounce_one", 32'(nv2), 32'd1);
        check("bounce_cmd", 32'(got_cmd), 32'h25);
        btn = '0; run(10);

        // SOUTH and EAST together
        do_reset();
        btn = 4'b1001; sw = 4'h7; nv = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (cmd_valid) begin nv++; got_cmd = {cmd_op, cmd_operand}; end
        end
        check("dual_one", 32'(nv), 32'd1);
        check("dual_cmd", 32'(got_cmd), 32'h07);
        check("dual_ovf", 32'(overflow), 32'd1);
        btn = '0; run(10);

        // Three presses into a stalled 2-entry queue
        do_reset();
        cmd_ready = 1'b0;
        press(4'b0001, 4'h1, 8);
        press(4'b0100, 4'h2, 8);
        press(4'b0010, 4'h3, 8);
        check("fill_ovf", 32'(overflow), 32'd1);
        check("fill_head0", 32'({cmd_valid, cmd_op, cmd_operand}), 32'h71);
        cmd_ready = 1'b1;
        step();
        check("fill_head1", 32'({cmd_valid, cmd_op, cmd_operand}), 32'h52);
        step();
        check("fill_empty", 32'(cmd_valid), 32'd0);

        // Push into a full queue on the same edge as a pop
        do_reset();
        cmd_ready = 1'b0;
        press(4'b0001, 4'h1, 8);
        press(4'b0100, 4'h2, 8);
        btn = 4'b0010; sw = 4'h3;
        run(5);
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        check("full_pp_ovf", 32'(overflow), 32'd0);
        check("full_pp_head", 32'({cmd_valid, cmd_op, cmd_operand}), 32'h52);
        btn = '0; run(8);
        cmd_ready = 1'b1; step();
        check("full_pp_new", 32'({cmd_valid, cmd_op, cmd_operand}), 32'h63);
        run(3);

        // Reset with one pending command and SOUTH mid-debounce
        cmd_ready = 1'b0;
        press(4'b0001, 4'h4, 8);
        btn = 4'b1000; sw = 4'hc;
        run(3);
        check("pre_rst_valid", 32'(cmd_valid), 32'd1);
        do_reset();
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            step();
            if (cmd_valid) lat = i;
        end
        check("rst_latency", 32'(lat), 32'd6);
        check("rst_cmd", 32'({cmd_op, cmd_operand}), 32'h0c);
        btn = '0; cmd_ready = 1'b1; run(10);

        // Randomized buttons, switches and back-pressure
        do_reset();
        for (int k = 0; k < 60; k++) begin
            btn = 4'($urandom);
            sw = 4'($urandom);
            for (int j = 0; j < int'($urandom_range(1, 12)); j++) begin
                cmd_ready = ($urandom_range(0, 3) != 0);
                step();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
